program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
Parametrised program counter for the highRISC core. Holds the fetch address, with a registered update every Clock edge. Supports increment, absolute load, signed relative branch, stall, and hardware call/return through an internal return-address stack (LIFO). Sits between the decoder/branch unit, which supplies the control strobes, and instruction memory, which consumes CounterValue.

Parameters:
WIDTH, 16, counter and address width in bits
OFFSET_WIDTH, 9, width of the signed two's-complement branch offset
STACK_DEPTH, 8, number of return-address entries (power of two, ≥2)
RESET_VECTOR, 0, value loaded into CounterValue on reset

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = in reset)
Stall  input  1  hold all state this cycle
LoadEnable  input  1  absolute jump to LoadValue
LoadValue  input  WIDTH  jump/call target
OffsetEnable  input  1  relative branch by Offset
Offset  input  OFFSET_WIDTH  signed branch offset
CallEnable  input  1  push return address, jump to LoadValue
ReturnEnable  input  1  pop return address into counter
CounterValue  output  WIDTH  current fetch address (registered)
StackCount  output  $clog2(STACK_DEPTH)+1  valid stack entries
StackOverflow  output  1  sticky: call attempted while full
StackUnderflow  output  1  sticky: return attempted while empty

Behaviour:
- Reset low (async): CounterValue=RESET_VECTOR, StackCount=0, StackOverflow=0, StackUnderflow=0. Stack storage contents are don't-care. Reset asserted mid-operation overrides everything immediately. The first update occurs on the first rising edge after Reset deasserts.
- All outputs are registered. A strobe sampled at edge N takes effect in CounterValue after edge N (1-cycle latency).
- Priority per edge, highest first: Stall > ReturnEnable > CallEnable > LoadEnable > OffsetEnable > increment.
- Stall=1: CounterValue, stack, StackCount and flags all hold. Other strobes are ignored.
- Return, StackCount>0: CounterValue←top entry; StackCount−1.
- Return, StackCount=0: CounterValue←CounterValue+1; StackUnderflow←1; StackCount stays 0.
- Call, StackCount<STACK_DEPTH: push CounterValue+1 (mod 2^WIDTH); CounterValue←LoadValue; StackCount+1.
- Call, StackCount=STACK_DEPTH: jump still taken; push dropped; existing entries untouched; StackOverflow←1.
- Load: CounterValue←LoadValue.
- Offset: CounterValue←CounterValue+sign_extend(Offset) to WIDTH. Wraps modulo 2^WIDTH in both directions. Offset=0 holds the address.
- Default: CounterValue←CounterValue+1, wrapping from 2^WIDTH−1 to 0.
- Strobes below the winning one in the same cycle are ignored entirely; e.g. Call+Return together acts as Return only, with no push.
- StackOverflow and StackUnderflow are sticky and clear only on reset.
- Stack is a register array plus pointer. No combinational path from any input to any output.

Test Plan:
- Reset low with Clock running → CounterValue=0x0000, StackCount=0, both flags 0. Release Reset, run 3 idle edges → 0x0001, 0x0002, 0x0003.
- CounterValue=0xFFFF, idle edge → 0x0000. At 0x0010 apply Offset=9'h1F0 (−16) → 0x0000. At 0x0000 apply Offset=−1 → 0xFFFF.
- At 0x0100, Call with LoadValue=0x2000 → CounterValue=0x2000, StackCount=1. Idle 2 edges (0x2002). Return → 0x0101, StackCount=0.
- Nested calls 9 times with STACK_DEPTH=8 → 9th call still jumps, StackCount=8, StackOverflow=1. Then 8 returns pop addresses in reverse order of calls 1–8. A 9th return → increment, StackUnderflow=1.
- Stall high for 4 edges while LoadEnable=1 → CounterValue and StackCount unchanged. Deassert Stall → load takes effect on the next edge.
- Reset pulsed low asynchronously between edges with StackCount=3 and both flags set → outputs go to reset values immediately, without waiting for a clock edge.
- Call+Return+LoadEnable asserted in one cycle with StackCount=2 → pop taken, StackCount=1, no push, LoadValue ignored.

Source files
------------

// File: rtl/program_counter_stack.sv
// Fetch program counter with increment, load, relative branch and
// a hardware return-address stack for call/return.
module program_counter_stack #(
    parameter int WIDTH        = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic                         LoadEnable,
    input  logic [WIDTH-1:0]             LoadValue,
    input  logic                         OffsetEnable,
    input  logic [OFFSET_WIDTH-1:0]      Offset,
    input  logic                         CallEnable,
    input  logic                         ReturnEnable,
    output logic [WIDTH-1:0]             CounterValue,
    output logic [$clog2(STACK_DEPTH):0] StackCount,
    output logic                         StackOverflow,
    output logic                         StackUnderflow
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;
    localparam int EXT = WIDTH - OFFSET_WIDTH;

    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] offset_ext;
    logic [WIDTH-1:0] top_entry;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    push_idx;
    logic             stack_full;
    logic             stack_empty;

    logic [WIDTH-1:0] next_pc;
    logic [CW-1:0]    next_count;
    logic             next_ovf;
    logic             next_unf;
    logic             push;

    assign pc_inc      = CounterValue + 1'b1;
    assign offset_ext  = {{EXT{Offset[OFFSET_WIDTH-1]}}, Offset};
    assign stack_full  = (StackCount == CW'(STACK_DEPTH));
    assign stack_empty = (StackCount == '0);
    assign top_idx     = PW'(StackCount - 1'b1);
    assign push_idx    = StackCount[PW-1:0];
    assign top_entry   = stack_mem[top_idx];

    // Lower-priority strobes are simply never examined once one wins.
    always_comb begin
        next_pc    = pc_inc;
        next_count = StackCount;
        next_ovf   = StackOverflow;
        next_unf   = StackUnderflow;
        push       = 1'b0;
        if (Stall) begin
            next_pc = CounterValue;
        end else if (ReturnEnable) begin
            if (stack_empty) begin
                next_unf = 1'b1;
            end else begin
                next_pc    = top_entry;
                next_count = StackCount - 1'b1;
            end
        end else if (CallEnable) begin
            next_pc = LoadValue;
            if (stack_full) begin
                next_ovf = 1'b1;
            end else begin
                push       = 1'b1;
                next_count = StackCount + 1'b1;
            end
        end else if (LoadEnable) begin
            next_pc = LoadValue;
        end else if (OffsetEnable) begin
            next_pc = CounterValue + offset_ext;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            CounterValue   <= WIDTH'(RESET_VECTOR);
            StackCount     <= '0;
            StackOverflow  <= 1'b0;
            StackUnderflow <= 1'b0;
        end else begin
            CounterValue   <= next_pc;
            StackCount     <= next_count;
            StackOverflow  <= next_ovf;
            StackUnderflow <= next_unf;
        end
    end

    // Storage needs no reset: entries above StackCount are never read.
    always_ff @(posedge Clock) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomized and directed bench for program_counter_stack against a
// queue-based reference model.
module tb_program_counter_stack;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        LoadEnable;
    logic [15:0] LoadValue;
    logic        OffsetEnable;
    logic [8:0]  Offset;
    logic        CallEnable;
    logic        ReturnEnable;
    logic [15:0] CounterValue;
    logic [3:0]  StackCount;
    logic        StackOverflow;
    logic        StackUnderflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    program_counter_stack #(
        .WIDTH(16), .OFFSET_WIDTH(9), .STACK_DEPTH(8), .RESET_VECTOR(0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall),
        .LoadEnable(LoadEnable), .LoadValue(LoadValue),
        .OffsetEnable(OffsetEnable), .Offset(Offset),
        .CallEnable(CallEnable), .ReturnEnable(ReturnEnable),
        .CounterValue(CounterValue), .StackCount(StackCount),
        .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        int s;
        if (Stall) return;
        if (ReturnEnable) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = m_pc + 16'd1; m_unf = 1'b1; end
        end else if (CallEnable) begin
            if (m_stack.size() < 8) m_stack.push_back(m_pc + 16'd1);
            else m_ovf = 1'b1;
            m_pc = LoadValue;
        end else if (LoadEnable) begin
            m_pc = LoadValue;
        end else if (OffsetEnable) begin
            s = Offset[8] ? int'(Offset) - 512 : int'(Offset);
            m_pc = 16'(int'(m_pc) + s);
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".pc"}, int'(CounterValue), int'(m_pc));
        check({tag, ".cnt"}, int'(StackCount), m_stack.size());
        check({tag, ".ovf"}, int'(StackOverflow), int'(m_ovf));
        check({tag, ".unf"}, int'(StackUnderflow), int'(m_unf));
    endtask

    task automatic idle();
        Stall = 0; LoadEnable = 0; OffsetEnable = 0;
        CallEnable = 0; ReturnEnable = 0;
        LoadValue = 16'h0; Offset = 9'h0;
    endtask

    // One clock: model follows the edge, then all outputs are compared.
    task automatic cycle(input string tag);
        @(posedge Clock);
        model_step();
        #1;
        compare(tag);
    endtask

    task automatic async_reset(input string tag);
        Reset = 1'b0;
        #1;
        model_reset();
        compare(tag);
        Reset = 1'b1;
    endtask

    initial begin
        idle();
        Reset = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        compare("rst");
        check("rst.lit", int'(CounterValue), 0);
        Reset = 1'b1;

        cycle("inc");
        check("inc1.lit", int'(CounterValue), 1);
        cycle("inc");
        cycle("inc");
        check("inc3.lit", int'(CounterValue), 3);

        LoadEnable = 1; LoadValue = 16'hFFFF;
        cycle("ldff");
        idle();
        cycle("wrap");
        check("wrap.lit", int'(CounterValue), 0);
        LoadEnable = 1; LoadValue = 16'h0010;
        cycle("ld10");
        idle(); OffsetEnable = 1; Offset = 9'h1F0;
        cycle("offm16");
        check("offm16.lit", int'(CounterValue), 0);
        Offset = 9'h1FF;
        cycle("offm1");
        check("offm1.lit", int'(CounterValue), 16'hFFFF);
        Offset = 9'h000;
        cycle("off0");

        idle(); LoadEnable = 1; LoadValue = 16'h0100;
        cycle("ld100");
        idle(); CallEnable = 1; LoadValue = 16'h2000;
        cycle("call");
        check("call.lit", int'(CounterValue), 16'h2000);
        idle();
        cycle("idle1");
        cycle("idle2");
        ReturnEnable = 1;
        cycle("ret");
        check("ret.lit", int'(CounterValue), 16'h0101);
        check("retcnt.lit", int'(StackCount), 0);

        for (int i = 0; i < 9; i++) begin
            idle(); CallEnable = 1;
            LoadValue = 16'h1000 + 16'(i * 16);
            cycle("nest");
        end
        check("nestcnt.lit", int'(StackCount), 8);
        check("nestovf.lit", int'(StackOverflow), 1);
        check("nestpc.lit", int'(CounterValue), 16'h1080);
        idle(); ReturnEnable = 1;
        for (int i = 0; i < 8; i++) cycle("pop");
        check("poplast.lit", int'(CounterValue), 16'h0102);
        cycle("under");
        check("under.lit", int'(StackUnderflow), 1);
        check("underpc.lit", int'(CounterValue), 16'h0103);

        idle(); CallEnable = 1; LoadValue = 16'h3000;
        cycle("c1");
        idle(); Stall = 1; LoadEnable = 1; LoadValue = 16'h4444;
        repeat (4) cycle("stall");
        check("stall.lit", int'(CounterValue), 16'h3000);
        Stall = 0;
        cycle("unstall");
        check("unstall.lit", int'(CounterValue), 16'h4444);

        idle(); CallEnable = 1; LoadValue = 16'h5000;
        cycle("c2");
        cycle("c3");
        idle();
        @(negedge Clock);
        async_reset("arst");
        check("arstcnt.lit", int'(StackCount), 0);

        idle(); CallEnable = 1; LoadValue = 16'h0600;
        cycle("c4");
        LoadValue = 16'h0700;
        cycle("c5");
        ReturnEnable = 1; LoadEnable = 1; LoadValue = 16'h0800;
        cycle("combo");
        check("combo.lit", int'(CounterValue), 16'h0601);
        check("combocnt.lit", int'(StackCount), 1);

        for (int i = 0; i < 3000; i++) begin
            idle();
            Stall        = ($urandom_range(0, 9) == 0);
            ReturnEnable = ($urandom_range(0, 4) == 0);
            CallEnable   = ($urandom_range(0, 3) == 0);
            LoadEnable   = ($urandom_range(0, 5) == 0);
            OffsetEnable = ($urandom_range(0, 2) == 0);
            LoadValue    = 16'($urandom);
            Offset       = 9'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                async_reset("rnd_rst");
            end
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
